// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set_bit(input logic [31:0] bits);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (bits[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_dwell_timer.sv
// Column dwell counter: tick marks the last cycle of each dwell (the sample point).
module keypad_dwell_timer #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobe, row synchronizer, press/release debounce
// and a single-entry valid/ack output buffer.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int KEY_ROW      = 4,
  parameter int KEY_COL      = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  localparam int CODE_W      = code_w(KEY_ROW, KEY_COL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_ROW-1:0] row_in,
  output logic [KEY_COL-1:0] col_drv,
  output logic [CODE_W-1:0]  key_code,
  output logic               key_valid,
  input  logic               key_ack,
  output logic               overrun,
  output logic               key_held
);

  localparam int ROW_W = (KEY_ROW > 1) ? $clog2(KEY_ROW) : 1;
  localparam int COL_W = (KEY_COL > 1) ? $clog2(KEY_COL) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

  logic [KEY_ROW-1:0] row_meta;
  logic [KEY_ROW-1:0] row_sync;
  logic               row_any;
  logic [ROW_W-1:0]   sel_row;
  logic               tick;
  logic               advance;
  logic               confirm;
  logic [CODE_W-1:0]  confirm_code;

  state_t             state;
  state_t             state_n;
  logic [DEB_W-1:0]   deb_cnt;
  logic [DEB_W-1:0]   deb_n;
  logic [ROW_W-1:0]   cur_row;
  logic [ROW_W-1:0]   cur_row_n;
  logic [COL_W-1:0]   cur_col;
  logic [COL_W-1:0]   cur_col_n;
  logic [COL_W-1:0]   col_idx;

  // Widen before multiplying so the code never truncates.
  function automatic logic [CODE_W-1:0] make_code(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return CODE_W'(32'(r) * 32'(KEY_COL) + 32'(c));
  endfunction

  keypad_dwell_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(advance),
    .tick   (tick)
  );

  assign row_any  = |row_sync;
  assign sel_row  = ROW_W'(lowest_set_bit(32'(row_sync)));
  assign col_drv  = KEY_COL'(1) << col_idx;
  assign key_held = (state == HELD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SCAN;
      deb_cnt <= '0;
      cur_row <= '0;
      cur_col <= '0;
      col_idx <= '0;
    end else begin
      state   <= state_n;
      deb_cnt <= deb_n;
      cur_row <= cur_row_n;
      cur_col <= cur_col_n;
      if (advance) begin
        col_idx <= (32'(col_idx) == KEY_COL - 1) ? '0 : col_idx + COL_W'(1);
      end
    end
  end

  // deb_cnt counts matching samples in DEBOUNCE and clear samples in HELD.
  always_comb begin
    state_n      = state;
    deb_n        = deb_cnt;
    cur_row_n    = cur_row;
    cur_col_n    = cur_col;
    advance      = 1'b0;
    confirm      = 1'b0;
    confirm_code = make_code(cur_row, cur_col);
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (!row_any) begin
            advance = 1'b1;
          end else begin
            cur_row_n    = sel_row;
            cur_col_n    = col_idx;
            deb_n        = DEB_W'(1);
            confirm_code = make_code(sel_row, col_idx);
            if (DEBOUNCE_CNT <= 1) begin
              confirm = 1'b1;
              state_n = HELD;
              deb_n   = '0;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (row_any && (sel_row == cur_row)) begin
            if (32'(deb_cnt) + 32'd1 >= 32'(DEBOUNCE_CNT)) begin
              confirm = 1'b1;
              state_n = HELD;
              deb_n   = '0;
            end else begin
              deb_n = deb_cnt + DEB_W'(1);
            end
          end else begin
            state_n = SCAN;
            advance = 1'b1;
            deb_n   = '0;
          end
        end
        HELD: begin
          if (row_any) begin
            deb_n = '0;
          end else if (32'(deb_cnt) + 32'd1 >= 32'(DEBOUNCE_CNT)) begin
            state_n = SCAN;
            advance = 1'b1;
            deb_n   = '0;
          end else begin
            deb_n = deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          state_n = SCAN;
          deb_n   = '0;
        end
      endcase
    end
  end

  // An ack in the load cycle frees the slot, so the new key replaces the old one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (confirm) begin
        if (!key_valid || key_ack) begin
          key_code  <= confirm_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with an emulated key matrix
// (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scan_ctrl;

  localparam int KEY_ROW      = 4;
  localparam int KEY_COL      = 4;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_ack = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_drv;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;
  logic       key_held;

  logic [3:0] pressed [4];
  logic       override_en = 1'b0;
  logic [3:0] override_val = 4'b0000;

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int ovr_count = 0;
  int ovr_before = 0;
  int held_low = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  keypad_scan_ctrl #(
    .KEY_ROW     (KEY_ROW),
    .KEY_COL     (KEY_COL),
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_drv  (col_drv),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overrun  (overrun),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to the driven column.
  always_comb begin
    row_in = 4'b0000;
    if (override_en) begin
      row_in = override_val;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (col_drv[c]) row_in = row_in | pressed[c];
      end
    end
  end

  // Dwell phase seen at the negedge; 3 marks a sample point.
  always @(posedge clk) begin
    if (!rst_n) phase <= 0;
    else phase <= (phase == SCAN_DIV - 1) ? 0 : phase + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // A new key appears when valid rises, or stays high after a consumed ack.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (key_valid && (!prev_valid || key_ack)) begin
        checkOutput("sb_event_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) checkOutput("sb_code", 32'(key_code), exp_q.pop_front());
      end
      if (overrun) ovr_count++;
      prev_valid <= key_valid;
    end
  end

  task automatic applyStimulus(input int col, input logic [3:0] rows);
    #1;
    pressed[col] = rows;
  endtask

  task automatic setAck(input logic v);
    #1;
    key_ack = v;
  endtask

  task automatic doReset();
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitSample(input string tag);
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      @(negedge clk);
      if (phase == SCAN_DIV - 1) return;
    end
    checkOutput(tag, 32'(phase), SCAN_DIV - 1);
  endtask

  task automatic waitColumn(input string tag, input logic [3:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (col_drv == target) return;
    end
    checkOutput(tag, 32'(col_drv), 32'(target));
  endtask

  task automatic waitValid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) return;
    end
    checkOutput(tag, 32'(key_valid), 1);
  endtask

  task automatic waitOverrun(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (overrun) return;
    end
    checkOutput(tag, 32'(overrun), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < 4; c++) pressed[c] = 4'b0000;

    // Power-on reset
    repeat (3) @(negedge clk);
    checkOutput("rst_col", 32'(col_drv), 1);
    checkOutput("rst_valid", 32'(key_valid), 0);
    checkOutput("rst_code", 32'(key_code), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_held", 32'(key_held), 0);
    #1 rst_n = 1'b1;

    // 1. Reset in the middle of debounce
    applyStimulus(1, 4'b0100);
    waitColumn("s1_col1", 4'b0010, 16);
    waitSample("s1_capture");
    @(negedge clk);
    #1;
    override_val = 4'b0100;
    override_en  = 1'b1;
    rst_n        = 1'b0;
    @(negedge clk);
    checkOutput("s1_rst_col", 32'(col_drv), 1);
    checkOutput("s1_rst_valid", 32'(key_valid), 0);
    checkOutput("s1_rst_overrun", 32'(overrun), 0);
    checkOutput("s1_rst_held", 32'(key_held), 0);
    @(negedge clk);
    #1;
    rst_n       = 1'b1;
    override_en = 1'b0;
    pressed[1]  = 4'b0000;
    @(negedge clk);
    checkOutput("s1_restart_col0", 32'(col_drv), 1);
    repeat (4) @(negedge clk);
    checkOutput("s1_scan_col1", 32'(col_drv), 2);

    // 2. Clean press at row 2, col 1
    doReset();
    exp_q.push_back(9);
    applyStimulus(1, 4'b0100);
    waitColumn("s2_col1", 4'b0010, 16);
    for (int k = 1; k <= 3; k++) begin
      waitSample("s2_sample");
      checkOutput($sformatf("s2_not_valid_at_sample%0d", k), 32'(key_valid), 0);
    end
    @(negedge clk);
    checkOutput("s2_valid_latency", 32'(key_valid), 1);
    checkOutput("s2_code", 32'(key_code), 9);
    checkOutput("s2_held", 32'(key_held), 1);
    applyStimulus(1, 4'b0000);
    setAck(1'b1);
    @(negedge clk);
    checkOutput("s2_ack_clear", 32'(key_valid), 0);
    setAck(1'b0);

    // 3. Bounce reject, plus an ack with nothing pending
    doReset();
    applyStimulus(1, 4'b0100);
    waitColumn("s3_col1", 4'b0010, 16);
    waitSample("s3_capture");
    applyStimulus(1, 4'b0000);
    setAck(1'b1);
    @(negedge clk);
    checkOutput("s3_ack_ignored", 32'(key_valid), 0);
    setAck(1'b0);
    waitSample("s3_reject");
    checkOutput("s3_col_held", 32'(col_drv), 2);
    @(negedge clk);
    checkOutput("s3_col_advance", 32'(col_drv), 4);
    checkOutput("s3_held", 32'(key_held), 0);
    checkOutput("s3_valid", 32'(key_valid), 0);

    // 4. Two rows at col 3, long hold, no repeat
    doReset();
    ovr_before = ovr_count;
    exp_q.push_back(7);
    applyStimulus(3, 4'b1010);
    waitColumn("s4_col3", 4'b1000, 32);
    waitValid("s4_valid", 32);
    checkOutput("s4_code", 32'(key_code), 7);
    setAck(1'b1);
    @(negedge clk);
    setAck(1'b0);
    held_low = 0;
    for (int k = 0; k < 20; k++) begin
      waitSample("s4_hold");
      if (!key_held) held_low++;
    end
    checkOutput("s4_held_throughout", 32'(held_low), 0);
    applyStimulus(3, 4'b0000);
    waitSample("s4_clear1");
    waitSample("s4_clear2");
    @(negedge clk);
    checkOutput("s4_held_after_2_clear", 32'(key_held), 1);
    waitSample("s4_clear3");
    @(negedge clk);
    checkOutput("s4_released", 32'(key_held), 0);
    checkOutput("s4_col_wrap", 32'(col_drv), 1);
    checkOutput("s4_no_overrun", 32'(ovr_count - ovr_before), 0);

    // 5. Second key confirmed with no ack
    doReset();
    ovr_before = ovr_count;
    exp_q.push_back(1);
    applyStimulus(1, 4'b0001);
    waitValid("s5_first", 40);
    applyStimulus(1, 4'b0000);
    applyStimulus(2, 4'b1000);
    waitOverrun("s5_overrun", 64);
    checkOutput("s5_code_kept", 32'(key_code), 1);
    checkOutput("s5_valid_kept", 32'(key_valid), 1);
    @(negedge clk);
    checkOutput("s5_overrun_width", 32'(overrun), 0);
    checkOutput("s5_overrun_count", 32'(ovr_count - ovr_before), 1);
    applyStimulus(2, 4'b0000);
    setAck(1'b1);
    @(negedge clk);
    checkOutput("s5_ack_clear", 32'(key_valid), 0);
    setAck(1'b0);

    // 6. Ack in the same cycle the second key loads
    doReset();
    ovr_before = ovr_count;
    exp_q.push_back(1);
    exp_q.push_back(14);
    applyStimulus(1, 4'b0001);
    waitValid("s6_first", 40);
    applyStimulus(1, 4'b0000);
    applyStimulus(2, 4'b1000);
    waitColumn("s6_col2", 4'b0100, 64);
    waitSample("s6_sample1");
    waitSample("s6_sample2");
    waitSample("s6_sample3");
    setAck(1'b1);
    @(negedge clk);
    checkOutput("s6_valid_stays", 32'(key_valid), 1);
    checkOutput("s6_new_code", 32'(key_code), 14);
    checkOutput("s6_no_overrun", 32'(overrun), 0);
    setAck(1'b0);
    @(negedge clk);
    checkOutput("s6_overrun_count", 32'(ovr_count - ovr_before), 0);
    applyStimulus(2, 4'b0000);
    setAck(1'b1);
    @(negedge clk);
    setAck(1'b0);

    repeat (2) @(negedge clk);
    checkOutput("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad on the calculator front end. It drives one-hot column strobes and samples the row lines through a synchronizer. It debounces press and release, then presents one key code per physical press to the calculator core over a valid/ack handshake. It owns all keypad timing, so the downstream decoder only ever sees clean, single key events.

Parameters:
KEY_ROW, 4, number of row sense lines
KEY_COL, 4, number of column drive lines
SCAN_DIV, 1000, clk cycles each column is driven (dwell); minimum 3
DEBOUNCE_CNT, 8, consecutive matching dwell samples needed to confirm press or release; minimum 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
row_in  in  KEY_ROW  raw row sense, active-high, asynchronous to clk
col_drv  out  KEY_COL  one-hot column strobe
key_code  out  CODE_W  confirmed key, equal to row*KEY_COL + col
key_valid  out  1  key_code holds an unacknowledged key
key_ack  in  1  consumer accepts key_code when high with key_valid
overrun  out  1  one-cycle pulse: confirmed key dropped because buffer full
key_held  out  1  high while FSM is in HELD

Behaviour:
- Reset (rst_n=0 sampled on clk edge; overrides all other activity, including mid-debounce or mid-handshake):
  - col_drv=1 (col 0), key_code=0, key_valid=0, overrun=0, key_held=0
  - state=SCAN; dwell counter, debounce counter and synchronizer flops cleared
- row_in passes through a 2-flop synchronizer. "row" below means the synchronized value.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. "Sample point" means counter==SCAN_DIV-1. Rows are evaluated only at sample points.
- Row select: if several rows are high, the lowest-index row wins.
- SCAN state:
  - At a sample point with row==0: col_drv rotates left on the next cycle (wraps MSB to bit 0) and the dwell counter restarts.
  - At a sample point with row!=0: capture cur_col and cur_row, set debounce count=1, go to DEBOUNCE. The column is not advanced.
  - If DEBOUNCE_CNT==1, the capture itself confirms the key.
- DEBOUNCE state (column held):
  - At each sample point, if the selected row equals cur_row, increment the count.
  - Otherwise, return to SCAN and advance to the next column.
  - When the count reaches DEBOUNCE_CNT, the key is confirmed: go to HELD.
- HELD state (column held, key_held=1):
  - Counts consecutive sample points where row==0. Any row high resets the count to 0.
  - Reaching DEBOUNCE_CNT returns to SCAN and advances the column.
  - A second key pressed while held is ignored. There is no auto-repeat.
- Output buffer (single entry), loaded on the cycle after the confirming sample point:
  - key_valid=0, or key_ack=1 in the same cycle: load key_code, set key_valid=1.
  - key_valid=1 and key_ack=0: keep the old code and pulse overrun for 1 cycle.
  - key_ack with key_valid=1 and no load: clear key_valid on the next edge.
  - key_ack with key_valid=0: ignored.
- Latency: a row change reaches the FSM 2 cycles later. key_valid rises 1 cycle after the final confirming sample point.
- Width: CODE_W=clog2(KEY_ROW*KEY_COL); the code computation must not truncate.

Decomposition:
- Package keypad_pkg holds:
  - CODE_W function/constant
  - state encodings SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2
  - the lowest-set-bit row encoder function
- Sub-module keypad_dwell_timer (params SCAN_DIV; ports clk, rst_n, restart, tick) generates the sample-point tick. The FSM, synchronizer and output buffer stay in keypad_scan_ctrl.

Test Plan:
All scenarios use the bench configuration SCAN_DIV=4, DEBOUNCE_CNT=3.
1. Reset:
   - Stimulus: rst_n=0 for 2 cycles mid-DEBOUNCE, with row_in=4'b0100.
   - Required: next edge gives col_drv=0001, key_valid=0, overrun=0. After release, scanning restarts from col 0.
2. Clean press:
   - Stimulus: hold row_in=4'b0100 whenever col_drv=0010, then ack.
   - Required: key_code=9 (row2*4+col1), key_valid=1 exactly one cycle after the 3rd matching sample point. key_ack for 1 cycle clears key_valid.
3. Bounce reject:
   - Stimulus: row_in=0100 for 1 sample, then 0 at the next sample.
   - Required: FSM back in SCAN, col_drv advances to 0100, key_valid stays 0.
4. Multi-row press plus hold with no repeat:
   - Stimulus: row_in=1010 at col 3, held for 20 dwells.
   - Required: single event key_code=7 (row1 wins). key_held=1 throughout; after release, 3 clear samples are needed before scanning resumes.
5. Overrun:
   - Stimulus: two keys confirmed without ack.
   - Required: overrun pulses 1 cycle and key_code retains the first code.
6. Ack on load cycle:
   - Stimulus: key_ack=1 in the same cycle as the second key loads.
   - Required: key_valid stays 1 with the new code, no overrun.
